// File: rtl/enc8to3_event_queue.sv
// rtl/enc8to3_event_queue.sv - 8-to-3 event encoder emitting one request index per handshake
// Optional build macro: ENC_LSB_FIRST_EN selects LSB-first priority (default MSB-first).
module enc8to3_event_queue #(
  parameter int N_IN   = 8,
  parameter int CODE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN-1:0]   req,
  input  logic              load,
  output logic              in_ready,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ready,
  output logic [CODE_W:0]   remaining,
  output logic              zero,
  output logic              overrun
);

  // Pending request bits; the IDLE/EMIT state is implied by pending_q being zero or not.
  logic [N_IN-1:0]   pending_q, pending_d;
  logic              zero_q, zero_d;
  logic              overrun_q, overrun_d;
  logic [CODE_W-1:0] code_c;
  logic [CODE_W:0]   count_c;
  logic              valid_c;

  // Priority select of the next index to emit from the registered pending set.
  always_comb begin
    code_c = '0;
`ifdef ENC_LSB_FIRST_EN
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (pending_q[i]) code_c = CODE_W'(i);
    end
`else
    for (int i = 0; i < N_IN; i++) begin
      if (pending_q[i]) code_c = CODE_W'(i);
    end
`endif
  end

  // Population count of pending bits for the remaining output.
  always_comb begin
    count_c = '0;
    for (int i = 0; i < N_IN; i++) begin
      count_c = count_c + {{CODE_W{1'b0}}, pending_q[i]};
    end
  end

  assign valid_c = (pending_q != '0);

  // Next-state: loads only land while idle; a load while busy just raises the sticky overrun.
  always_comb begin
    pending_d = pending_q;
    zero_d    = 1'b0;
    overrun_d = overrun_q;
    if (!valid_c) begin
      if (load) begin
        pending_d = req;
        zero_d    = (req == '0);
      end
    end else begin
      if (ready) begin
        pending_d = pending_q & ~(N_IN'(1) << code_c);
      end
      if (load) begin
        overrun_d = 1'b1;
      end
    end
  end

  // State registers; reset overrides both load and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      zero_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      zero_q    <= zero_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid     = valid_c;
  assign in_ready  = ~valid_c;
  assign code      = code_c;
  assign remaining = count_c;
  assign zero      = zero_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/enc8to3_event_queue.md
Name: enc8to3_event_queue

Overview:
- Inverse of the team's 3-to-8 decoder: an 8-to-3 encoder that captures an 8-bit request pattern and emits the 3-bit index of every set bit, one per handshake.
- Default priority is MSB-first, so bit 7 maps to code 3'b111, matching decoder output O7.
- Sits between interrupt/event sources and a consumer that accepts one binary code at a time.

Parameters:
- N_IN, 8, number of request lines; must equal 2**CODE_W.
- CODE_W, 3, width of the emitted code.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  N_IN  request pattern, sampled on load.
- load  input  1  capture strobe.
- in_ready  output  1  high when no codes are pending; load is accepted only in this state.
- code  output  CODE_W  index of the current highest-priority pending bit.
- valid  output  1  code is meaningful.
- ready  input  1  consumer accepts code.
- remaining  output  CODE_W+1  number of pending bits, 0..8.
- zero  output  1  one-cycle pulse when a load captured req==0.
- overrun  output  1  sticky flag: a load arrived while in_ready was low.

Behaviour:
- State is an N_IN-bit pending register P, plus the zero and overrun flags.
- Reset (rst high at a clk edge): P=0, zero=0, overrun=0. Outputs after reset: valid=0, in_ready=1, remaining=0, code=0.
- valid = (P != 0); in_ready = ~valid. Both are derived from registered state only.
- code = index of the highest set bit of P. When P==0, code=0.
- remaining = popcount(P).
- Two states, implied by P:
  - IDLE (P==0): load=1 sets P<=req at the edge.
  - EMIT (P!=0): waits for handshakes.
- Load latency: load sampled at edge k gives valid=1 and a correct code after edge k, i.e. in cycle k+1.
- Load with req==0: P stays 0, state stays IDLE, zero=1 for exactly the following cycle.
- Handshake: valid&&ready at an edge clears bit `code` of P. The next code (or valid=0) appears after that edge. With ready held high, codes stream one per cycle with no bubbles.
- valid/code stability: while valid=1 and ready=0, code and remaining hold unchanged. req changes are ignored after capture.
- Load while in_ready=0, including the same cycle as the final handshake:
  - load is ignored and P is unaffected;
  - overrun<=1, and it stays 1 until rst.
- No new load can be accepted until the cycle after P reaches 0. Throughput is therefore n handshakes plus 1 load cycle per pattern.
- Reset mid-EMIT: pending codes are discarded, valid=0 in the next cycle, overrun and zero are cleared.
- rst has priority over load and over handshakes in the same cycle.

Optional Feature:
- Macro: ENC_LSB_FIRST_EN.
- Defined: priority is LSB-first; code is the index of the lowest set bit of P. All handshake, latency and flag rules are unchanged.
- Undefined (default): MSB-first, as specified above.

Test Plan:
- Reset then idle → valid=0, in_ready=1, remaining=0, zero=0, overrun=0.
- load with req=8'b1010_0101, ready=1 held:
  - cycle after load: valid=1, remaining=4;
  - codes 7,5,2,0 on 4 consecutive cycles;
  - then valid=0, in_ready=1.
  - With ENC_LSB_FIRST_EN defined: order is 0,2,5,7.
- load req=8'h80, ready=0 for 5 cycles → code=7, valid=1, remaining=1 held stable throughout. Raise ready → one handshake, then valid=0.
- load req=8'h00 → zero high for exactly 1 cycle, valid stays 0, in_ready stays 1.
- load req=8'h03, then a second load on the cycle of the final handshake → overrun=1, only codes 1,0 are emitted, P=0 afterwards. overrun stays 1 until rst pulse.
- load req=8'hFF, complete 3 handshakes, assert rst → next cycle valid=0, remaining=0, in_ready=1. A fresh load of 8'h10 then yields code 4.
